// File: rtl/mcht_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mcht_pkg                                                     |
// | Description : Shared constants, state encodings and helpers for the        |
// |               Manchester transceiver (encoder in the top, decoder in       |
// |               mcht_rx).                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mcht_pkg;

    // Default clock cycles per Manchester half-bit.
    localparam int HALF_BIT_CYC_DEF = 4;

    // One start symbol plus eight data bits.
    localparam int FRAME_SYMS = 9;

    // Idle-low guard appended after every transmitted frame (one bit period).
    localparam int GUARD_CYC = 2 * HALF_BIT_CYC_DEF;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_DATA  = 2'd1,
        TX_GUARD = 2'd2
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // Guard length for a non-default half-bit setting.
    function automatic int guard_cyc(input int half_bit_cyc);
        return 2 * half_bit_cyc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcht_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcht_rx                                                      |
// | Description : Manchester frame decoder. Line source select, 2-flop         |
// |               synchronizer, start-edge detection and fixed-offset symbol   |
// |               sampling (no mid-frame resynchronization).                   |
// | Ports       : clk, rst_n       - clock / async active-low reset            |
// |               i_line_rx        - external receive line                     |
// |               i_line_tx        - local transmit line (loopback source)     |
// |               i_loopback       - 1 selects i_line_tx                       |
// |               o_byte           - last completed frame's byte               |
// |               o_valid, o_err   - frame done / code violation seen          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mcht_rx
    import mcht_pkg::*;
#(
    parameter int HALF_BIT_CYC = HALF_BIT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_line_rx,
    input  logic       i_line_tx,
    input  logic       i_loopback,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_err
);

    localparam int SYM_CYC = 2 * HALF_BIT_CYC;
    localparam int PW      = $clog2(SYM_CYC);

    localparam logic [PW-1:0] SAMP1    = PW'(HALF_BIT_CYC / 2);
    localparam logic [PW-1:0] SAMP2    = PW'((HALF_BIT_CYC * 3) / 2);
    localparam logic [PW-1:0] POS_LAST = PW'(SYM_CYC - 1);
    localparam logic [3:0]    SYM_LAST = 4'(FRAME_SYMS - 1);

    rx_state_t      r_state;
    rx_state_t      w_state_nxt;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_prev;
    logic [PW-1:0]  r_pos;
    logic [3:0]     r_sym;
    logic           r_first;
    logic [7:0]     r_data;
    logic [7:0]     r_byte;
    logic           r_valid;
    logic           r_err;

    logic w_line_in;
    logic w_rise;
    logic w_samp2;
    logic w_done;

    // Loopback is muxed ahead of the synchronizer so both sources see
    // identical latency.
    assign w_line_in = i_loopback ? i_line_tx : i_line_rx;
    assign w_rise    = r_sync2 & ~r_prev;
    assign w_samp2   = (r_state == RX_SHIFT) && (r_pos == SAMP2);
    assign w_done    = w_samp2 && (r_sym == SYM_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (w_rise) w_state_nxt = RX_SHIFT;
            RX_SHIFT: if (w_done) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pos   <= '0;
            r_sym   <= '0;
            r_first <= 1'b0;
            r_data  <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= w_line_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            case (r_state)
                RX_IDLE: begin
                    // The edge cycle is position 0 of the start symbol.
                    if (w_rise) begin
                        r_pos   <= PW'(1);
                        r_sym   <= '0;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                RX_SHIFT: begin
                    if (r_pos == POS_LAST) begin
                        r_pos <= '0;
                        r_sym <= r_sym + 4'd1;
                    end else begin
                        r_pos <= r_pos + 1'b1;
                    end
                    if (r_pos == SAMP1) begin
                        r_first <= r_sync2;
                    end
                    if (w_samp2) begin
                        // Equal halves is a code violation; a start symbol
                        // must decode as 0.
                        if ((r_first == r_sync2) || ((r_sym == 4'd0) && r_sync2)) begin
                            r_err <= 1'b1;
                        end
                        if (r_sym != 4'd0) begin
                            r_data <= {r_sync2, r_data[7:1]};
                        end
                        if (w_done) begin
                            r_byte  <= {r_sync2, r_data[7:1]};
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_byte  = r_byte;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/tt_um_patrick_lin_git_mcht_trx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tt_um_patrick_lin_git_mcht_trx                               |
// | Description : Manchester (IEEE 802.3) byte transceiver. Encoder and pin    |
// |               mapping live here; decoding is done by mcht_rx.              |
// | Ports       : clk, rst_n  - clock / async active-low reset                 |
// |               ena         - tile select (unused)                           |
// |               ui_in       - TX byte, latched on accepted start             |
// |               uo_out      - last received byte                             |
// |               uio_in      - [0] tx_start, [1] rx_line, [2] loopback        |
// |               uio_out     - [4] tx_line, [5] tx_busy, [6] rx_valid,        |
// |                             [7] rx_err                                     |
// |               uio_oe      - fixed 8'hF0                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tt_um_patrick_lin_git_mcht_trx
    import mcht_pkg::*;
#(
    parameter int HALF_BIT_CYC = HALF_BIT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int GUARD_LEN = guard_cyc(HALF_BIT_CYC);
    localparam int CNT_W     = $clog2(GUARD_LEN) + 1;

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_BIT_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);
    localparam logic [3:0]       SYM_LAST   = 4'(FRAME_SYMS - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic              r_start_q;
    logic [8:0]        r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_half;
    logic [3:0]        r_sym;
    logic              r_tx_line;

    logic       w_busy;
    logic       w_start_acc;
    logic       w_half_end;
    logic       w_guard_end;
    logic       w_last_sym;
    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;
    logic       w_unused;

    assign w_busy      = (r_state != TX_IDLE);
    assign w_start_acc = uio_in[0] & ~r_start_q & ~w_busy;
    assign w_half_end  = (r_cnt == HALF_LAST);
    assign w_guard_end = (r_cnt == GUARD_LAST);
    assign w_last_sym  = (r_sym == SYM_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:  if (w_start_acc) w_state_nxt = TX_DATA;
            TX_DATA:  if (w_half_end && r_half && w_last_sym) w_state_nxt = TX_GUARD;
            TX_GUARD: if (w_guard_end) w_state_nxt = TX_IDLE;
            default:  w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The shift register carries the start symbol (0) in bit 0 followed by
    // the data LSB first. First half of each symbol is the inverted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_half    <= 1'b0;
            r_sym     <= '0;
            r_tx_line <= 1'b0;
        end else begin
            r_start_q <= uio_in[0];
            case (r_state)
                TX_IDLE: begin
                    if (w_start_acc) begin
                        r_shreg   <= {ui_in, 1'b0};
                        r_cnt     <= '0;
                        r_half    <= 1'b0;
                        r_sym     <= '0;
                        r_tx_line <= 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (!r_half) begin
                            r_half    <= 1'b1;
                            r_tx_line <= r_shreg[0];
                        end else begin
                            r_half    <= 1'b0;
                            r_shreg   <= {1'b0, r_shreg[8:1]};
                            r_sym     <= r_sym + 4'd1;
                            r_tx_line <= w_last_sym ? 1'b0 : ~r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_GUARD: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    mcht_rx #(
        .HALF_BIT_CYC (HALF_BIT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_line_rx  (uio_in[1]),
        .i_line_tx  (r_tx_line),
        .i_loopback (uio_in[2]),
        .o_byte     (w_rx_byte),
        .o_valid    (w_rx_valid),
        .o_err      (w_rx_err)
    );

    assign uo_out   = w_rx_byte;
    assign uio_out  = {w_rx_err, w_rx_valid, w_busy, r_tx_line, 4'b0000};
    assign uio_oe   = 8'hF0;
    assign w_unused = &{1'b0, ena, uio_in[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_patrick_lin_git_mcht_trx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tt_um_patrick_lin_git_mcht_trx                            |
// | Description : Self-checking bench for the Manchester transceiver with a    |
// |               waveform-level reference model of encoding and decoding.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tt_um_patrick_lin_git_mcht_trx;

    localparam int HB      = 4;
    localparam int SYM     = 2 * HB;
    localparam int FRAME   = 9 * SYM;
    localparam int TX_TOT  = FRAME + SYM;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    tt_um_patrick_lin_git_mcht_trx #(
        .HALF_BIT_CYC (HB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tx_line k cycles after the frame begins.
    function automatic logic tx_model(input logic [7:0] b, input int k);
        int   s;
        logic bitv;
        logic second;
        if (k >= FRAME) return 1'b0;
        s      = k / SYM;
        second = ((k % SYM) >= HB);
        bitv   = (s == 0) ? 1'b0 : b[s-1];
        return second ? bitv : ~bitv;
    endfunction

    task automatic wait_valid(input logic lvl, input int max, output logic ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            if (uio_out[6] === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic wait_idle(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (uio_out[5] === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_start(input logic [7:0] b);
        ui_in     = b;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        ui_in     = ~b;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) tick();
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL reset_uo_out got %h want 00", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL reset_uio_out got %h want 00", uio_out);
        else n_pass++;
        n_checks++;
        if (uio_oe !== 8'hF0) $display("FAIL uio_oe got %h want f0", uio_oe);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL post_reset_idle got %h want 00", uio_out);
        else n_pass++;
    endtask

    task automatic test_tx_waveform(input logic [7:0] b);
        int bad;
        uio_in = 8'h00;
        pulse_start(b);
        bad = 0;
        for (int k = 0; k < TX_TOT; k++) begin
            n_checks++;
            if (uio_out[4] !== tx_model(b, k) || uio_out[5] !== 1'b1) begin
                if (bad < 4)
                    $display("FAIL tx_wave byte=%h cyc=%0d line=%b busy=%b want line=%b busy=1",
                             b, k, uio_out[4], uio_out[5], tx_model(b, k));
                bad++;
            end else n_pass++;
            tick();
        end
        n_checks++;
        if (uio_out[5] !== 1'b0 || uio_out[4] !== 1'b0)
            $display("FAIL tx_end byte=%h busy=%b line=%b want 0 0", b, uio_out[5], uio_out[4]);
        else n_pass++;
    endtask

    task automatic test_loopback(input logic [7:0] b);
        logic ok;
        int   c1;
        int   c2;
        uio_in = 8'h04;
        pulse_start(b);
        wait_valid(1'b0, 20, ok, c1);
        n_checks++;
        if (!ok) $display("FAIL lb_valid_clear byte=%h valid=%b want 0", b, uio_out[6]);
        else n_pass++;
        wait_valid(1'b1, 100, ok, c2);
        n_checks++;
        if (!ok || (c1 + c2) >= TX_TOT)
            $display("FAIL lb_latency byte=%h cycles=%0d want <%0d", b, c1 + c2, TX_TOT);
        else n_pass++;
        n_checks++;
        if (uo_out !== b) $display("FAIL lb_byte got %h want %h", uo_out, b);
        else n_pass++;
        n_checks++;
        if (uio_out[7] !== 1'b0) $display("FAIL lb_err byte=%h got %b want 0", b, uio_out[7]);
        else n_pass++;
        wait_idle(100, ok);
        n_checks++;
        if (!ok) $display("FAIL lb_busy_end byte=%h busy=%b want 0", b, uio_out[5]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_loopback(8'h00);
        test_loopback(8'hFF);
        for (int i = 0; i < 3; i++) test_loopback(8'($urandom));
    endtask

    // h[2s] / h[2s+1] are the first / second halves of symbol s.
    task automatic test_rx_halves(input logic [17:0] h);
        logic [7:0] exp_b;
        logic       exp_e;
        logic       ok;
        int         c;
        exp_e = h[1];
        exp_b = 8'h00;
        for (int s = 0; s < 9; s++) if (h[2*s] == h[2*s+1]) exp_e = 1'b1;
        for (int s = 1; s < 9; s++) exp_b[s-1] = h[2*s+1];
        uio_in = 8'h00;
        for (int i = 0; i < 18; i++) begin
            uio_in[1] = h[i];
            repeat (HB) tick();
            if (i == 4) begin
                n_checks++;
                if (uio_out[6] !== 1'b0) $display("FAIL rx_valid_midframe got %b want 0", uio_out[6]);
                else n_pass++;
            end
        end
        uio_in[1] = 1'b0;
        wait_valid(1'b1, 20, ok, c);
        n_checks++;
        if (!ok) $display("FAIL rx_done halves=%h valid=%b want 1", h, uio_out[6]);
        else n_pass++;
        n_checks++;
        if (uo_out !== exp_b) $display("FAIL rx_byte halves=%h got %h want %h", h, uo_out, exp_b);
        else n_pass++;
        n_checks++;
        if (uio_out[7] !== exp_e) $display("FAIL rx_err halves=%h got %b want %b", h, uio_out[7], exp_e);
        else n_pass++;
        repeat (2 * SYM) tick();
    endtask

    task automatic test_rx_legal(input logic [7:0] b);
        logic [17:0] h;
        h[0] = 1'b1;
        h[1] = 1'b0;
        for (int s = 1; s < 9; s++) begin
            h[2*s]   = ~b[s-1];
            h[2*s+1] =  b[s-1];
        end
        test_rx_halves(h);
    endtask

    task automatic test_busy_ignore();
        logic [7:0] b;
        int         cnt;
        b      = 8'($urandom);
        uio_in = 8'h04;
        pulse_start(b);
        cnt = 0;
        while (uio_out[5] === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 20) begin
                ui_in     = b ^ 8'h5A;
                uio_in[0] = 1'b1;
            end
            if (cnt == 21) uio_in[0] = 1'b0;
            tick();
        end
        n_checks++;
        if (cnt != TX_TOT) $display("FAIL busy_len got %0d want %0d", cnt, TX_TOT);
        else n_pass++;
        n_checks++;
        if (uo_out !== b || uio_out[6] !== 1'b1)
            $display("FAIL busy_ignore_byte got %h valid=%b want %h valid=1", uo_out, uio_out[6], b);
        else n_pass++;
        repeat (SYM) tick();
        n_checks++;
        if (uio_out[5] !== 1'b0) $display("FAIL busy_no_restart busy=%b want 0", uio_out[5]);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        uio_in = 8'h04;
        pulse_start(8'($urandom));
        repeat (29) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL midreset_uo_out got %h want 00", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL midreset_uio_out got %h want 00", uio_out);
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        test_loopback(8'h3C);
    endtask

    initial begin
        test_reset();
        test_tx_waveform(8'h01);
        for (int i = 0; i < 3; i++) test_tx_waveform(8'($urandom));
        test_loopback(8'hA5);
        test_back_to_back();
        test_rx_halves(18'b111111111111111101);
        for (int i = 0; i < 3; i++) test_rx_legal(8'($urandom));
        for (int i = 0; i < 4; i++) test_rx_halves(18'($urandom) | 18'h1);
        test_busy_ignore();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_patrick_lin_git_mcht_trx.md
TT_UM_PATRICK_LIN_GIT_MCHT_TRX -- requirements
Module: tt_um_patrick_lin_git_mcht_trx

Interface
REQ-001 SHALL have parameter HALF_BIT_CYC, default 4, meaning clock cycles per Manchester half-bit (bit period = 2*HALF_BIT_CYC = 8 clocks).
REQ-002 SHALL have port clk  in  1  system clock, all flops rising-edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ena  in  1  tile-selected flag; it does not gate any logic.
REQ-005 SHALL have port ui_in  in  8  TX data byte, sampled on accepted start.
REQ-006 SHALL have port uo_out  out  8  last received byte (rx_byte).
REQ-007 SHALL have port uio_in  in  8  [0]=tx_start, [1]=rx_line, [2]=loopback, [7:3] ignored.
REQ-008 SHALL have port uio_out  out  8  [4]=tx_line, [5]=tx_busy, [6]=rx_valid, [7]=rx_err, [3:0]=0.
REQ-009 SHALL have port uio_oe  out  8  constant 8'hF0.

Function
REQ-010 Line coding SHALL be IEEE 802.3 Manchester: bit 1 = low half then high half; bit 0 = high half then low half; idle line = low.
REQ-011 A frame SHALL be one start symbol (coded 0: high,low) followed by 8 data bits LSB first; 9 symbols = 72 clocks at default.
REQ-012 tx_start SHALL be registered; a 0->1 transition while tx_busy=0 is an accepted start; starts while busy SHALL be ignored.
REQ-013 On an accepted start, ui_in SHALL be latched in that cycle, tx_busy SHALL rise and tx_line SHALL go high on the next clock.
REQ-014 TX SHALL hold each half-bit for exactly HALF_BIT_CYC clocks, then drive tx_line low for a one-bit guard (8 clocks); tx_busy SHALL fall after the guard (total 80 clocks).
REQ-015 RX input SHALL be uio_in[1] through a 2-flop synchronizer when loopback=0, and the internal tx_line unsynchronized-by-wire (still through the same synchronizer) when loopback=1.
REQ-016 RX states SHALL be IDLE, SHIFT; IDLE->SHIFT on a synchronized 0->1 edge, which defines start-bit time zero.
REQ-017 In SHIFT, each symbol SHALL be sampled at offsets HALF_BIT_CYC/2 and HALF_BIT_CYC*3/2 from its start; decoded bit = second sample.
REQ-018 Equal first/second samples (code violation), or start symbol not decoding as 0, SHALL set rx_err.
REQ-019 After the 9th symbol's second sample, RX SHALL load rx_byte to uo_out, set rx_valid=1 and return to IDLE the same cycle.
REQ-020 rx_valid and rx_err SHALL hold until the next RX start edge, at which both clear; uo_out holds until the next completed frame.
REQ-021 A frame with rx_err set SHALL still update uo_out and assert rx_valid.
REQ-022 RX SHALL not resynchronize mid-frame; both ends run from the same nominal clock.

Reset
REQ-023 While rst_n=0: tx_line=0, tx_busy=0, rx_valid=0, rx_err=0, uo_out=8'h00, synchronizer flops=0, both FSMs idle.
REQ-024 Reset mid-frame SHALL abort TX and RX immediately; after release the next tx_start 0->1 starts a clean frame.

Structure
REQ-025 Package mcht_pkg SHALL hold HALF_BIT_CYC default, FRAME_SYMS=9, GUARD_CYC, and TX/RX state enums.
REQ-026 The decoder SHALL be sub-module mcht_rx (synchronizer, FSM, sample counters); encoder and pin mapping stay in the top.

Verification
REQ-027 Loopback=1, ui_in=8'hA5, pulse tx_start -> within 80 clocks uo_out=8'hA5, rx_valid=1, rx_err=0.
REQ-028 ui_in=8'h01, start -> tx_line per 4-clock half: H,L, L,H, then H,L x7, then low; tx_busy high exactly 80 clocks.
REQ-029 Loopback=0, drive rx_line high 4/low 4 (start) then hold high 64 clocks -> rx_valid=1, rx_err=1.
REQ-030 Second tx_start pulse 20 clocks into frame -> ignored, byte unchanged, tx_busy falls at clock 80.
REQ-031 Assert rst_n=0 at clock 30 of a frame -> all outputs 0 at once; fresh 8'h3C frame afterwards received correctly.
REQ-032 Back-to-back loopback frames 8'h00 then 8'hFF -> uo_out 8'h00 then 8'hFF, rx_err=0 each.
